// File: rtl/fifo_sync_param_if.sv
// Producer/consumer handshake bundle for fifo_sync_param.
// master = FIFO user (drives requests), slave = FIFO.
interface fifo_sync_param_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [CW-1:0]         count;

  modport master (
    output wr_en, rd_en, data_in,
    input  data_out, data_valid, wr_ack, overflow, underflow,
           full, empty, almostfull, almostempty, count
  );

  modport slave (
    input  wr_en, rd_en, data_in,
    output data_out, data_valid, wr_ack, overflow, underflow,
           full, empty, almostfull, almostempty, count
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO, any DEPTH >= 2, with occupancy count and status strobes.
// Define FIFO_FWFT_EN for first-word-fall-through; default is registered 1-cycle read.
module fifo_sync_param #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic              clk,
  input  logic              rst,
  fifo_sync_param_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_ack_q, overflow_q, underflow_q;
  logic                  full, empty, wr_acc, rd_acc;

  // Explicit wrap so non-power-of-2 depths index correctly.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  // A read at full frees the slot the write lands in.
  assign wr_acc = bus.wr_en & (~full | bus.rd_en);
  assign rd_acc = bus.rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[wr_ptr_q] <= bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_acc;
      overflow_q  <= bus.wr_en & ~wr_acc;
      underflow_q <= bus.rd_en & ~rd_acc;
    end
  end

`ifdef FIFO_FWFT_EN
  assign bus.data_out   = mem[rd_ptr_q];
  assign bus.data_valid = ~empty & ~rst;
`else
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  data_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= rd_acc;
      if (rd_acc) data_out_q <= mem[rd_ptr_q];
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
`endif

  assign bus.wr_ack      = wr_ack_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
  assign bus.count       = count_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almostfull  = (count_q >= CW'(AF_THRESH));
  assign bus.almostempty = (count_q <= CW'(AE_THRESH));
endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param: DEPTH=8 main instance, DEPTH=6 wrap instance.
// Honours FIFO_FWFT_EN to switch the expected read timing.
module tb_fifo_sync_param;
  localparam int DW = 16;
  localparam int D8 = 8;
  localparam int D6 = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_sync_param_if #(.DATA_WIDTH(DW), .DEPTH(D8)) b8 ();
  fifo_sync_param_if #(.DATA_WIDTH(DW), .DEPTH(D6)) b6 ();

  fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(D8)) u_dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
  fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(D6)) u_dut6 (.clk(clk), .rst(rst), .bus(b6.slave));

  int            n_run  = 0;
  int            n_fail = 0;
  logic [DW-1:0] sb_q [$];
  int            mdl_cnt  = 0;
  logic [DW-1:0] last_out = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle on DUT8, update the scoreboard, check everything after the edge.
  task automatic step8(input bit wr, input bit rd, input logic [DW-1:0] d);
    bit            wr_ok, rd_ok;
    logic [DW-1:0] hd;
    hd = '0;
    b8.wr_en = wr; b8.rd_en = rd; b8.data_in = d;
    wr_ok = wr && (mdl_cnt < D8 || rd);
    rd_ok = rd && (mdl_cnt > 0);
    if (rd_ok) hd = sb_q.pop_front();
    if (wr_ok) sb_q.push_back(d);
    mdl_cnt = sb_q.size();
    @(posedge clk); #1;
    chk("wr_ack",      b8.wr_ack,      wr_ok);
    chk("overflow",    b8.overflow,    wr && !wr_ok);
    chk("underflow",   b8.underflow,   rd && !rd_ok);
    chk("count",       b8.count,       mdl_cnt);
    chk("full",        b8.full,        mdl_cnt == D8);
    chk("empty",       b8.empty,       mdl_cnt == 0);
    chk("almostfull",  b8.almostfull,  mdl_cnt >= D8 - 1);
    chk("almostempty", b8.almostempty, mdl_cnt <= 1);
`ifdef FIFO_FWFT_EN
    if (mdl_cnt > 0) begin
      chk("fwft_valid", b8.data_valid, 1'b1);
      chk("fwft_head",  b8.data_out,   sb_q[0]);
    end else begin
      chk("fwft_valid", b8.data_valid, 1'b0);
    end
`else
    if (rd_ok) begin
      chk("data_valid", b8.data_valid, 1'b1);
      chk("data_out",   b8.data_out,   hd);
      last_out = hd;
    end else begin
      chk("data_valid", b8.data_valid, 1'b0);
      chk("data_hold",  b8.data_out,   last_out);
    end
`endif
  endtask

  task automatic reset_all();
    rst = 1'b1;
    b8.wr_en = 1'b1; b8.rd_en = 1'b0; b8.data_in = 16'hFFFF;
    b6.wr_en = 1'b1; b6.rd_en = 1'b0; b6.data_in = 16'hFFFF;
    @(posedge clk); #1;
    chk("rst_count",  b8.count,       0);
    chk("rst_empty",  b8.empty,       1'b1);
    chk("rst_full",   b8.full,        1'b0);
    chk("rst_ae",     b8.almostempty, 1'b1);
    chk("rst_wr_ack", b8.wr_ack,      1'b0);
    chk("rst_valid",  b8.data_valid,  1'b0);
    chk("rst6_count", b6.count,       0);
`ifndef FIFO_FWFT_EN
    chk("rst_dout",   b8.data_out,    16'h0000);
`endif
    rst = 1'b0;
    b8.wr_en = 1'b0; b6.wr_en = 1'b0;
    sb_q.delete();
    mdl_cnt  = 0;
    last_out = '0;
  endtask

  initial begin
    rst = 1'b1;
    b8.wr_en = 1'b0; b8.rd_en = 1'b0; b8.data_in = '0;
    b6.wr_en = 1'b0; b6.rd_en = 1'b0; b6.data_in = '0;
    reset_all();

    // Fill, overflow, drain, underflow.
    for (int i = 1; i <= D8; i++) step8(1'b1, 1'b0, DW'(i));
    step8(1'b1, 1'b0, 16'h0009);
    for (int i = 0; i < D8; i++) step8(1'b0, 1'b1, '0);
    step8(1'b0, 1'b1, '0);

    // Simultaneous at empty, then at full.
    step8(1'b1, 1'b1, 16'h0055);
    step8(1'b0, 1'b1, '0);
    for (int i = 1; i <= D8; i++) step8(1'b1, 1'b0, DW'(16'h0020 + i));
    step8(1'b1, 1'b1, 16'h0077);
    step8(1'b0, 1'b0, '0);

    // Reset with the FIFO full discards contents.
    reset_all();

    // Interleaved single write/read crossing the wrap point.
    for (int i = 0; i < 20; i++) begin
      step8(1'b1, 1'b0, DW'(16'h0100 + i));
      step8(1'b0, 1'b1, '0);
    end

    // Random mix.
    for (int i = 0; i < 200; i++)
      step8(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), DW'($urandom));
    b8.wr_en = 1'b0; b8.rd_en = 1'b0;

    // DEPTH=6 wrap run.
    for (int i = 0; i < 20; i++) begin
      b6.wr_en = 1'b1; b6.data_in = DW'(16'h0100 + i);
      @(posedge clk); #1;
      b6.wr_en = 1'b0;
      chk("d6_wr_count", b6.count,  1);
      chk("d6_wr_ack",   b6.wr_ack, 1'b1);
`ifdef FIFO_FWFT_EN
      chk("d6_fwft_valid", b6.data_valid, 1'b1);
      chk("d6_fwft_head",  b6.data_out,   DW'(16'h0100 + i));
`endif
      b6.rd_en = 1'b1;
      @(posedge clk); #1;
      b6.rd_en = 1'b0;
      chk("d6_rd_count", b6.count,     0);
      chk("d6_empty",    b6.empty,     1'b1);
      chk("d6_underflow", b6.underflow, 1'b0);
`ifdef FIFO_FWFT_EN
      chk("d6_fwft_valid", b6.data_valid, 1'b0);
`else
      chk("d6_valid", b6.data_valid, 1'b1);
      chk("d6_dout",  b6.data_out,   DW'(16'h0100 + i));
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
